// File: rtl/z80_bus_responder.sv
// Bus-side responder for the z80 core: decodes M1/MEM/IO/INTA cycles, inserts
// fixed or LFSR-random wait states, serves reads from a byte RAM / I/O latch.
module z80_bus_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned M1_WAIT   = 0,
    parameter int unsigned MEM_WAIT  = 0,
    parameter int unsigned IO_WAIT   = 0,
    parameter bit          RAND_WAIT = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [7:0]  INTA_VEC  = 8'hFF
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    input  logic        nRFSH,
    input  logic [7:0]  WRITE_D,
    output logic [7:0]  READ_D,
    output logic        nWAIT,
    output logic [15:0] bus_cycles,
    output logic [15:0] wait_cycles
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_e;
    typedef enum logic [1:0] {C_M1, C_MEM, C_IO, C_INTA} cls_e;

    logic [7:0]           ram_q [DEPTH];
    state_e               state_q;
    cls_e                 cls_q;
    logic [3:0]           cnt_q;
    logic [15:0]          lfsr_q;
    logic [15:0]          bus_q;
    logic [15:0]          waitc_q;
    logic [7:0]           rdata_q;
    logic [7:0]           io_q;
    logic                 nwait_q;

    logic [ADDR_BITS-1:0] addr;
    logic                 a_unused;
    logic                 mem_req;
    logic                 io_req;
    logic                 start;
    logic                 strobe;
    cls_e                 cls_d;
    logic [3:0]           base;
    logic [3:0]           n_d;
    logic [15:0]          lfsr_d;

    assign addr     = A[ADDR_BITS-1:0];
    assign a_unused = ^A[15:ADDR_BITS];

    // Cycle classification and wait-count selection; memory wins over I/O if both are low.
    always_comb begin
        mem_req = !nMREQ && nRFSH;
        io_req  = !nIORQ && nRFSH;
        start   = mem_req || io_req;
        strobe  = !nMREQ || !nIORQ;
        cls_d   = C_IO;
        base    = 4'(IO_WAIT);
        if (mem_req) begin
            if (!nM1) begin
                cls_d = C_M1;
                base  = 4'(M1_WAIT);
            end else begin
                cls_d = C_MEM;
                base  = 4'(MEM_WAIT);
            end
        end else if (!nM1) begin
            cls_d = C_INTA;
            base  = 4'd0;
        end
        if (RAND_WAIT)
            n_d = 4'({1'b0, lfsr_q[3:0]} % (5'(base) + 5'd1));
        else
            n_d = base;
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            cls_q   <= C_MEM;
            cnt_q   <= 4'd0;
            lfsr_q  <= LFSR_SEED;
            bus_q   <= 16'd0;
            waitc_q <= 16'd0;
            rdata_q <= 8'hFF;
            io_q    <= 8'hFF;
            nwait_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bus_q  <= bus_q + 16'd1;
                        lfsr_q <= lfsr_d;
                        cls_q  <= cls_d;
                        cnt_q  <= n_d;
                        if (n_d != 4'd0) begin
                            state_q <= S_WAIT;
                            nwait_q <= 1'b0;
                        end else begin
                            state_q <= S_ACTIVE;
                        end
                    end
                end
                S_WAIT: begin
                    waitc_q <= waitc_q + 16'd1;
                    if (!strobe) begin
                        state_q <= S_IDLE;
                        nwait_q <= 1'b1;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= S_ACTIVE;
                        nwait_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACTIVE: begin
                    if (!strobe) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    nwait_q <= 1'b1;
                end
            endcase

            if (state_q != S_IDLE && !nRD) begin
                case (cls_q)
                    C_IO:    rdata_q <= io_q;
                    C_INTA:  rdata_q <= INTA_VEC;
                    default: rdata_q <= ram_q[addr];
                endcase
            end

            if (state_q == S_ACTIVE && !nWR && cls_q == C_IO) io_q <= WRITE_D;
        end
    end

    // RAM contents survive reset; writes only commit in ACTIVE.
    always_ff @(posedge CLK) begin
        if (state_q == S_ACTIVE && !nWR && cls_q == C_MEM) ram_q[addr] <= WRITE_D;
    end

    assign READ_D      = rdata_q;
    assign nWAIT       = nwait_q;
    assign bus_cycles  = bus_q;
    assign wait_cycles = waitc_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Self-checking bench: fixed-wait and random-wait responders on a shared bus,
// checked against a reference RAM / LFSR model.
module tb_z80_bus_responder;

    localparam int K_M1   = 0;
    localparam int K_MEM  = 1;
    localparam int K_IO   = 2;
    localparam int K_INTA = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [7:0]  wd;
    logic [7:0]  rd_f, rd_r;
    logic        nwait_f, nwait_r;
    logic [15:0] bus_f, bus_r, wc_f, wc_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    z80_bus_responder #(
        .ADDR_BITS(8), .M1_WAIT(2), .MEM_WAIT(0), .IO_WAIT(1),
        .RAND_WAIT(1'b0), .LFSR_SEED(16'hACE1), .INTA_VEC(8'hCF)
    ) u_fix (
        .CLK(clk), .nRESET(rst_n), .A(a), .nMREQ(mreq_n), .nIORQ(iorq_n),
        .nRD(rd_n), .nWR(wr_n), .nM1(m1_n), .nRFSH(rfsh_n), .WRITE_D(wd),
        .READ_D(rd_f), .nWAIT(nwait_f), .bus_cycles(bus_f), .wait_cycles(wc_f)
    );

    z80_bus_responder #(
        .ADDR_BITS(8), .M1_WAIT(0), .MEM_WAIT(3), .IO_WAIT(0),
        .RAND_WAIT(1'b1), .LFSR_SEED(16'hACE1), .INTA_VEC(8'hFF)
    ) u_rnd (
        .CLK(clk), .nRESET(rst_n), .A(a), .nMREQ(mreq_n), .nIORQ(iorq_n),
        .nRD(rd_n), .nWR(wr_n), .nM1(m1_n), .nRFSH(rfsh_n), .WRITE_D(wd),
        .READ_D(rd_r), .nWAIT(nwait_r), .bus_cycles(bus_r), .wait_cycles(wc_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    // One complete bus cycle; nw counts negedges with the selected responder's nWAIT low.
    task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic wr,
                             input logic [7:0] data, input bit sel,
                             output logic [7:0] rdata, output int nw);
        int guard;
        @(negedge clk);
        a      = addr;
        wd     = data;
        rfsh_n = 1'b1;
        mreq_n = !(kind == K_M1 || kind == K_MEM);
        iorq_n = !(kind == K_IO || kind == K_INTA);
        m1_n   = !(kind == K_M1 || kind == K_INTA);
        rd_n   = wr;
        wr_n   = !wr;
        nw     = 0;
        guard  = 0;
        @(negedge clk);
        while ((sel ? nwait_r : nwait_f) == 1'b0 && guard < 40) begin
            nw++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 40) check("wait_bound", 32'(guard), 32'd0);
        @(negedge clk);
        rdata = sel ? rd_r : rd_f;
        bus_idle();
    endtask

    logic [7:0]  rdat;
    int          nw;
    int          exp_bus;
    int          exp_wait;
    logic [7:0]  mem_model [256];
    bit          valid [256];
    logic [15:0] lfsr_m;
    int          n_exp;
    int          wsum;
    logic        nwait_ok;
    logic        is_wr;
    logic [15:0] ad;
    logic [7:0]  dt;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a = 16'h0000;
        wd = 8'h00;
        bus_idle();
        repeat (2) @(negedge clk);
        check("rst_read_d", 32'(rd_f), 32'hFF);
        check("rst_nwait", 32'(nwait_f), 32'h1);
        check("rst_bus_cycles", 32'(bus_f), 32'h0);
        check("rst_wait_cycles", 32'(wc_f), 32'h0);
        check("rst_read_d_rnd", 32'(rd_r), 32'hFF);
        rst_n = 1'b1;
        exp_bus = 0;
        exp_wait = 0;

        // M1 fetch with two wait states after preloading RAM[0x10]
        bus_cycle(K_MEM, 16'h0010, 1'b1, 8'h3E, 1'b0, rdat, nw); exp_bus++;
        check("preload_waits", 32'(nw), 32'd0);
        bus_cycle(K_M1, 16'h0010, 1'b0, 8'h00, 1'b0, rdat, nw); exp_bus++; exp_wait += 2;
        check("m1_waits", 32'(nw), 32'd2);
        check("m1_read_d", 32'(rdat), 32'h3E);
        check("m1_wait_cycles", 32'(wc_f), 32'(exp_wait));
        check("m1_bus_cycles", 32'(bus_f), 32'(exp_bus));

        // Address aliasing above ADDR_BITS
        bus_cycle(K_MEM, 16'h0120, 1'b1, 8'h5A, 1'b0, rdat, nw); exp_bus++;
        check("alias_wr_waits", 32'(nw), 32'd0);
        bus_cycle(K_MEM, 16'h0020, 1'b0, 8'h00, 1'b0, rdat, nw); exp_bus++;
        check("alias_rd_waits", 32'(nw), 32'd0);
        check("alias_read_d", 32'(rdat), 32'h5A);

        // I/O out/in and interrupt acknowledge
        bus_cycle(K_IO, 16'h00C3, 1'b1, 8'hC3, 1'b0, rdat, nw); exp_bus++; exp_wait += 1;
        check("out_waits", 32'(nw), 32'd1);
        bus_cycle(K_IO, 16'h00C3, 1'b0, 8'h00, 1'b0, rdat, nw); exp_bus++; exp_wait += 1;
        check("in_waits", 32'(nw), 32'd1);
        check("in_read_d", 32'(rdat), 32'hC3);
        bus_cycle(K_INTA, 16'h0000, 1'b0, 8'h00, 1'b0, rdat, nw); exp_bus++;
        check("inta_waits", 32'(nw), 32'd0);
        check("inta_read_d", 32'(rdat), 32'hCF);
        check("io_wait_cycles", 32'(wc_f), 32'(exp_wait));

        // Refresh with nWR low must be ignored entirely
        @(negedge clk);
        a = 16'h0010; wd = 8'hEE; m1_n = 1'b1; mreq_n = 1'b0; rfsh_n = 1'b0; wr_n = 1'b0;
        nwait_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            nwait_ok = nwait_ok & nwait_f;
        end
        bus_idle();
        check("rfsh_nwait", 32'(nwait_ok), 32'h1);
        check("rfsh_bus_cycles", 32'(bus_f), 32'(exp_bus));
        bus_cycle(K_MEM, 16'h0010, 1'b0, 8'h00, 1'b0, rdat, nw); exp_bus++;
        check("rfsh_ram_kept", 32'(rdat), 32'h3E);

        // Asynchronous reset in the middle of a wait phase
        @(negedge clk);
        a = 16'h0010; mreq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        check("midwait_nwait_low", 32'(nwait_f), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_nwait", 32'(nwait_f), 32'h1);
        check("midrst_read_d", 32'(rd_f), 32'hFF);
        check("midrst_bus_cycles", 32'(bus_f), 32'h0);
        check("midrst_wait_cycles", 32'(wc_f), 32'h0);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Random memory traffic against LFSR wait model and RAM model
        lfsr_m = 16'hACE1;
        wsum = 0;
        for (int i = 0; i < 256; i++) valid[i] = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            ad    = 16'($urandom);
            dt    = 8'($urandom);
            n_exp = int'(lfsr_m[3:0]) % 4;
            lfsr_m = lfsr_step(lfsr_m);
            wsum += n_exp;
            bus_cycle(K_MEM, ad, is_wr, dt, 1'b1, rdat, nw);
            check("rnd_waits", 32'(nw), 32'(n_exp));
            if (is_wr) begin
                mem_model[ad[7:0]] = dt;
                valid[ad[7:0]] = 1'b1;
            end else if (valid[ad[7:0]]) begin
                check("rnd_read_d", 32'(rdat), 32'(mem_model[ad[7:0]]));
                check("fix_read_d", 32'(rd_f), 32'(mem_model[ad[7:0]]));
            end
        end
        check("rnd_wait_cycles", 32'(wc_r), 32'(wsum));
        check("rnd_bus_cycles", 32'(bus_r), 32'd1000);
        check("fix_wait_cycles", 32'(wc_f), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
